// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store.
// Optional fetch aging: define MEM_ARB_AGING_EN (limit set by MAX_WAIT).
module mem_arbiter #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_D    = 2'd2
    } resp_t;

    resp_t resp_sel;
    resp_t resp_next;
    logic  fetch_first;

`ifdef MEM_ARB_AGING_EN
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (!if_req || if_gnt) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_LIM) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign fetch_first = (wait_cnt == WAIT_LIM);
`else
    logic unused_max_wait;

    assign unused_max_wait = ^4'(MAX_WAIT);
    assign fetch_first     = 1'b0;
`endif

    // Data wins ties unless fetch has aged out; nothing is granted in reset.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!reset) begin
            if (if_req && (fetch_first || !d_req)) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr  = '0;
        ram_din   = '0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        resp_next = RESP_NONE;
        if (if_gnt) begin
            ram_addr  = if_addr;
            ram_din   = d_wdata;
            ram_re    = 1'b1;
            resp_next = RESP_IF;
        end else if (d_gnt) begin
            ram_addr = d_addr;
            ram_din  = d_wdata;
            ram_re   = !d_we;
            ram_we   = d_we;
            if (!d_we) begin
                resp_next = RESP_D;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_sel <= RESP_NONE;
        end else begin
            resp_sel <= resp_next;
        end
    end

    // A response still in flight when reset arrives is discarded.
    assign if_rvalid = (resp_sel == RESP_IF) && !reset;
    assign d_rvalid  = (resp_sel == RESP_D) && !reset;
    assign if_rdata  = ram_dout;
    assign d_rdata   = ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle RAM.
// Aging expectations follow MEM_ARB_AGING_EN as the design does.
module tb_mem_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_re;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_re(ram_re), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    // Program word preloaded while reset is held.
    always @(posedge clk) begin
        if (reset) begin
            mem[16] <= 32'h0050_0093;
        end else if (ram_we) begin
            mem[ram_addr[7:0]] <= ram_din;
        end
        if (ram_re) begin
            ram_dout <= mem[ram_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int prev;
        logic exp_if;

        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;

        // Reset state, requests masked while reset is high.
        step();
        step();
        if_req  = 1'b1;
        if_addr = 30'h10;
        #1;
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_ram_re", 32'(ram_re), 32'd0);

        // Fetch of 0x10.
        step();
        reset = 1'b0;
        #1;
        check("f_gnt", 32'(if_gnt), 32'd1);
        check("f_addr", 32'(ram_addr), 32'h10);
        check("f_re", 32'(ram_re), 32'd1);
        check("f_rvalid_early", 32'(if_rvalid), 32'd0);
        step();
        if_req = 1'b0;
        #1;
        check("f_rvalid", 32'(if_rvalid), 32'd1);
        check("f_rdata", if_rdata, 32'h0050_0093);
        check("f_gnt_idle", 32'(if_gnt), 32'd0);

        // Data write then read back.
        step();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 30'h20;
        d_wdata = 32'hDEAD_BEEF;
        #1;
        check("w_gnt", 32'(d_gnt), 32'd1);
        check("w_we", 32'(ram_we), 32'd1);
        check("w_re", 32'(ram_re), 32'd0);
        check("w_addr", 32'(ram_addr), 32'h20);
        check("w_din", ram_din, 32'hDEAD_BEEF);
        step();
        d_we = 1'b0;
        #1;
        check("r_gnt", 32'(d_gnt), 32'd1);
        check("r_re", 32'(ram_re), 32'd1);
        check("w_no_rvalid", 32'(d_rvalid), 32'd0);
        step();
        d_req = 1'b0;
        #1;
        check("r_rvalid", 32'(d_rvalid), 32'd1);
        check("r_rdata", d_rdata, 32'hDEAD_BEEF);
        check("idle_re", 32'(ram_re), 32'd0);
        check("idle_addr", 32'(ram_addr), 32'h0);

        // Simultaneous requests: data first, then fetch.
        step();
        if_req  = 1'b1;
        if_addr = 30'h10;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 30'h20;
        #1;
        check("s0_d_gnt", 32'(d_gnt), 32'd1);
        check("s0_if_gnt", 32'(if_gnt), 32'd0);
        check("s0_addr", 32'(ram_addr), 32'h20);
        step();
        d_req = 1'b0;
        #1;
        check("s1_if_gnt", 32'(if_gnt), 32'd1);
        check("s1_d_rvalid", 32'(d_rvalid), 32'd1);
        check("s1_d_rdata", d_rdata, 32'hDEAD_BEEF);
        check("s1_addr", 32'(ram_addr), 32'h10);
        step();
        if_req = 1'b0;
        #1;
        check("s2_if_rvalid", 32'(if_rvalid), 32'd1);
        check("s2_if_rdata", if_rdata, 32'h0050_0093);
        check("s2_d_rvalid", 32'(d_rvalid), 32'd0);

        // Read granted the cycle before a reset pulse is dropped.
        step();
        d_req = 1'b1;
        #1;
        check("rr_gnt", 32'(d_gnt), 32'd1);
        step();
        d_req = 1'b0;
        reset = 1'b1;
        #1;
        check("rr_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rr_if_rvalid", 32'(if_rvalid), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("rr_after_rvalid", 32'(d_rvalid), 32'd0);
        check("rr_after_re", 32'(ram_re), 32'd0);
        check("rr_after_we", 32'(ram_we), 32'd0);

        // Continuous data reads with fetch held for 20 cycles.
        step();
        if_req = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        prev   = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
`ifdef MEM_ARB_AGING_EN
            exp_if = (i % 5 == 0);
`else
            exp_if = 1'b0;
`endif
            check($sformatf("age_if_gnt_%0d", i), 32'(if_gnt),
                  32'(exp_if));
            check($sformatf("age_d_gnt_%0d", i), 32'(d_gnt),
                  32'(!exp_if));
            check($sformatf("age_d_rvalid_%0d", i), 32'(d_rvalid),
                  32'(prev == 2));
            prev = exp_if ? 1 : 2;
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        step();

        // Alternating fetch/data reads, responses in grant order.
        prev = 0;
        for (int i = 0; i < 9; i++) begin
            if_req = (i < 8) && (i % 2 == 0);
            d_req  = (i < 8) && (i % 2 == 1);
            #1;
            check($sformatf("alt_if_gnt_%0d", i), 32'(if_gnt),
                  32'(if_req));
            check($sformatf("alt_d_gnt_%0d", i), 32'(d_gnt),
                  32'(d_req));
            check($sformatf("alt_if_rv_%0d", i), 32'(if_rvalid),
                  32'(prev == 1));
            check($sformatf("alt_d_rv_%0d", i), 32'(d_rvalid),
                  32'(prev == 2));
            if (prev == 1) begin
                check($sformatf("alt_if_rd_%0d", i), if_rdata,
                      32'h0050_0093);
            end
            if (prev == 2) begin
                check($sformatf("alt_d_rd_%0d", i), d_rdata,
                      32'hDEAD_BEEF);
            end
            prev = if_req ? 1 : (d_req ? 2 : 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
